// File: rtl/store_seq_checker_pkg.sv
// Shared types and helpers for the store-sequence checker: size/fail/state
// encodings, data-lane masking and minimum-one-bit width helper.
package store_chk_pkg;

    typedef enum logic [1:0] {ST_NONE, ST_WORD, ST_HALF, ST_BYTE} st_size_e;
    typedef enum logic [1:0] {F_NONE, F_ADDR, F_DATA, F_TIMEOUT} fail_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

    // Bits of right-aligned store data that are significant for a given size
    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        logic [31:0] m;
        m = 32'h0000_0000;
        case (st_size_e'(sz))
            ST_WORD: m = 32'hFFFF_FFFF;
            ST_HALF: m = 32'h0000_FFFF;
            ST_BYTE: m = 32'h0000_00FF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // $clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/store_seq_checker_lane_cmp.sv
// Combinational compare of one store against one expected entry:
// address+size equality and size-masked data equality.
module store_lane_cmp
    import store_chk_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_exp_size,
    input  logic [ADDR_W-1:0] i_exp_addr,
    input  logic [DATA_W-1:0] i_exp_data,
    output logic              o_addr_ok_c,
    output logic              o_data_ok_c
);

    logic [DATA_W-1:0] w_mask;

    assign w_mask      = DATA_W'(size_mask(i_size));
    assign o_addr_ok_c = (i_addr == i_exp_addr) && (i_size == i_exp_size);
    assign o_data_ok_c = ((i_data & w_mask) == (i_exp_data & w_mask));

endmodule

// File: rtl/store_seq_checker.sv
// In-order checker of committed MIPS stores against a loadable expected table.
// Optional macro STORE_SEQ_CHECKER_LOG_EN prints the verdict in simulation.
module store_seq_checker
    import store_chk_pkg::*;
#(
    parameter int unsigned N_EXP   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        memwrite,
    input  logic [ADDR_W-1:0]                 dataadr,
    input  logic [DATA_W-1:0]                 writedata,
    input  logic                              exp_we,
    input  logic [clog2_min1(N_EXP)-1:0]      exp_idx,
    input  logic [ADDR_W-1:0]                 exp_addr,
    input  logic [DATA_W-1:0]                 exp_data,
    input  logic [1:0]                        exp_size,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [1:0]                        fail_code,
    output logic [clog2_min1(N_EXP)-1:0]      fail_idx,
    output logic [$clog2(N_EXP+1)-1:0]        match_cnt
);

    localparam int unsigned IDX_W = clog2_min1(N_EXP);
    localparam int unsigned MC_W  = $clog2(N_EXP + 1);
    localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(N_EXP - 1);

    logic [ADDR_W-1:0] r_tab_addr [N_EXP];
    logic [DATA_W-1:0] r_tab_data [N_EXP];
    logic [1:0]        r_tab_size [N_EXP];

    state_e            r_state,  w_nxt_state;
    logic [IDX_W-1:0]  r_ptr,    w_nxt_ptr;
    logic [CNT_W-1:0]  r_cnt,    w_nxt_cnt;
    logic [MC_W-1:0]   r_match,  w_nxt_match;
    fail_e             r_fcode,  w_nxt_fcode;
    logic [IDX_W-1:0]  r_fidx,   w_nxt_fidx;
    logic              r_busy, r_done, r_pass;

    logic              w_store;
    logic              w_addr_ok;
    logic              w_data_ok;

    // Expected table survives reset so a run can be restarted without reloading
    always_ff @(posedge clk) begin
        if (exp_we && (r_state != S_RUN) && (32'(exp_idx) < N_EXP)) begin
            r_tab_addr[exp_idx] <= exp_addr;
            r_tab_data[exp_idx] <= exp_data;
            r_tab_size[exp_idx] <= exp_size;
        end
    end

    assign w_store = (memwrite != 2'b00);

    store_lane_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .i_size      (memwrite),
        .i_addr      (dataadr),
        .i_data      (writedata),
        .i_exp_size  (r_tab_size[r_ptr]),
        .i_exp_addr  (r_tab_addr[r_ptr]),
        .i_exp_data  (r_tab_data[r_ptr]),
        .o_addr_ok_c (w_addr_ok),
        .o_data_ok_c (w_data_ok)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_match <= '0;
            r_fcode <= F_NONE;
            r_fidx  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_match <= w_nxt_match;
            r_fcode <= w_nxt_fcode;
            r_fidx  <= w_nxt_fidx;
            r_busy  <= (w_nxt_state == S_RUN);
            r_done  <= (w_nxt_state == S_PASS) || (w_nxt_state == S_FAIL);
            r_pass  <= (w_nxt_state == S_PASS);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_nxt_match = r_match;
        w_nxt_fcode = r_fcode;
        w_nxt_fidx  = r_fidx;
        case (r_state)
            S_RUN: begin
                if (w_store) begin
                    // Address/size mismatch outranks data mismatch
                    if (!w_addr_ok) begin
                        w_nxt_state = S_FAIL;
                        w_nxt_fcode = F_ADDR;
                        w_nxt_fidx  = r_ptr;
                    end else if (!w_data_ok) begin
                        w_nxt_state = S_FAIL;
                        w_nxt_fcode = F_DATA;
                        w_nxt_fidx  = r_ptr;
                    end else begin
                        w_nxt_match = r_match + MC_W'(1);
                        w_nxt_cnt   = '0;
                        if (r_match == MC_LAST) begin
                            w_nxt_state = S_PASS;
                        end else begin
                            w_nxt_ptr = r_ptr + IDX_W'(1);
                        end
                    end
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LIM)) begin
                    w_nxt_state = S_FAIL;
                    w_nxt_fcode = F_TIMEOUT;
                    w_nxt_fidx  = r_ptr;
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    w_nxt_state = S_RUN;
                    w_nxt_ptr   = '0;
                    w_nxt_cnt   = '0;
                    w_nxt_match = '0;
                    w_nxt_fcode = F_NONE;
                    w_nxt_fidx  = '0;
                end
            end
        endcase
    end

`ifdef STORE_SEQ_CHECKER_LOG_EN
    always_ff @(posedge clk) begin
        if (reset && (r_state == S_RUN)) begin
            if (w_nxt_state == S_PASS) begin
                $display("Simulation succeeded");
            end else if (w_nxt_state == S_FAIL) begin
                $display("Simulation failed: cause=%0d idx=%0d dataadr=%h writedata=%h",
                         w_nxt_fcode, w_nxt_fidx, dataadr, writedata);
            end
        end
    end
`else
    // Logging disabled: silent build
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fcode;
    assign fail_idx  = r_fidx;
    assign match_cnt = r_match;

endmodule

// File: tb/tb_store_seq_checker.sv
// Directed bench for store_seq_checker: a 4-entry/TIMEOUT=16 instance and a
// 1-entry instance for the single-store case.
module tb_store_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_size;
    logic        start;
    logic        start1;

    logic        busy, done, pass;
    logic [1:0]  fail_code, fail_idx;
    logic [2:0]  match_cnt;
    logic        busy1, done1, pass1;
    logic [1:0]  fail_code1;
    logic        fail_idx1;
    logic        match_cnt1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    store_seq_checker #(.N_EXP(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_size(exp_size),
        .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .fail_idx(fail_idx), .match_cnt(match_cnt)
    );

    store_seq_checker #(.N_EXP(1), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut1 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx[0:0]),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_size(exp_size),
        .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_code(fail_code1), .fail_idx(fail_idx1), .match_cnt(match_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] idx, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
        exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d; exp_size = sz;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        memwrite = sz; dataadr = a; writedata = d;
        tick();
        memwrite = 2'b00;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reference table for the 4-entry instance
    logic [31:0] ta [4] = '{32'd84, 32'd86, 32'd80, 32'd88};
    logic [31:0] td [4] = '{32'h12345678, 32'h0000BEEF, 32'h0000007F, 32'h0};
    logic [1:0]  ts [4] = '{2'b01, 2'b10, 2'b11, 2'b01};

    initial begin
        reset = 1'b0; memwrite = 2'b00; dataadr = '0; writedata = '0;
        exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0; exp_size = '0;
        start = 1'b0; start1 = 1'b0;
        idle(2);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_pass", 32'(pass), 0);
        chk("reset_fcode", 32'(fail_code), 0);
        chk("reset_match", 32'(match_cnt), 0);
        reset = 1'b1;
        tick();

        // Single byte store on the 1-entry instance; upper data bits ignored
        load(2'd0, 32'd80, 32'h000000FF, 2'b11);
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t1_busy", 32'(busy1), 1);
        store(32'd80, 32'h0000AAFF, 2'b11);
        chk("t1_pass", 32'(pass1), 1);
        chk("t1_done", 32'(done1), 1);
        chk("t1_match", 32'(match_cnt1), 1);

        // Full sequence with 3-cycle gaps
        for (int i = 0; i < 4; i++) load(2'(i), ta[i], td[i], ts[i]);
        do_start();
        chk("t2_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            idle(3);
            chk("t2_pass_early", 32'(pass), 0);
            store(ta[i], td[i], ts[i]);
            chk("t2_match", 32'(match_cnt), 32'(i + 1));
        end
        chk("t2_pass", 32'(pass), 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_low", 32'(busy), 0);

        // Address/size mismatch at entry 1: byte store where half expected
        do_start();
        chk("t3_fcode_clr", 32'(fail_code), 0);
        chk("t3_match_clr", 32'(match_cnt), 0);
        store(ta[0], td[0], ts[0]);
        store(32'd86, 32'h0000BEEF, 2'b11);
        chk("t3_fcode", 32'(fail_code), 1);
        chk("t3_fidx", 32'(fail_idx), 1);
        chk("t3_match", 32'(match_cnt), 1);
        chk("t3_done", 32'(done), 1);
        chk("t3_pass", 32'(pass), 0);
        store(ta[1], td[1], ts[1]);
        chk("t3_sticky_fcode", 32'(fail_code), 1);
        chk("t3_sticky_match", 32'(match_cnt), 1);

        // Data mismatch on byte entry 2
        do_start();
        store(ta[0], td[0], ts[0]);
        store(ta[1], td[1], ts[1]);
        store(32'd80, 32'hFFFFFF7E, 2'b11);
        chk("t4_fcode", 32'(fail_code), 2);
        chk("t4_fidx", 32'(fail_idx), 2);
        chk("t4_match", 32'(match_cnt), 2);
        do_start();
        store(ta[0], td[0], ts[0]);
        store(ta[1], 32'hA5A5BEEF, ts[1]);
        store(32'd80, 32'hFFFFFF7F, 2'b11);
        chk("t4_upper_ignored", 32'(match_cnt), 3);
        chk("t4_no_fail", 32'(fail_code), 0);
        store(ta[3], td[3], ts[3]);
        chk("t4_pass", 32'(pass), 1);

        // Timeout fires exactly 16 cycles after RUN entry
        do_start();
        idle(15);
        chk("t5_busy_15", 32'(busy), 1);
        chk("t5_fcode_15", 32'(fail_code), 0);
        tick();
        chk("t5_fcode_16", 32'(fail_code), 3);
        chk("t5_fidx", 32'(fail_idx), 0);
        chk("t5_done", 32'(done), 1);

        // Store in the expiry cycle wins over the timeout
        do_start();
        idle(15);
        store(ta[0], td[0], ts[0]);
        chk("t5_store_match", 32'(match_cnt), 1);
        chk("t5_store_fcode", 32'(fail_code), 0);
        chk("t5_store_busy", 32'(busy), 1);

        // Reset after two matches, then rerun from the retained table
        store(ta[1], td[1], ts[1]);
        chk("t6_match2", 32'(match_cnt), 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_pass", 32'(pass), 0);
        chk("t6_match", 32'(match_cnt), 0);
        chk("t6_fidx", 32'(fail_idx), 0);
        store(ta[0], td[0], ts[0]);
        chk("t6_idle_ignores", 32'(match_cnt), 0);
        do_start();
        for (int i = 0; i < 4; i++) store(ta[i], td[i], ts[i]);
        chk("t6_rerun_match", 32'(match_cnt), 4);
        chk("t6_rerun_pass", 32'(pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/store_seq_checker.md
Name: store_seq_checker

Overview:
- Synthesizable, self-checking monitor on the pipelined MIPS data-memory write port.
- Compares every committed store (word, halfword or byte) in order against a loadable table of N_EXP expected stores.
- Reports PASS, or FAIL with a cause code and the failing index.
- Generalises the single-address, single-store check to a parametrised sequence with size awareness and a timeout.

Parameters:
- N_EXP, 4: number of expected-store table entries (1..64).
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width (must be 32).
- TIMEOUT, 1024: max cycles allowed between start/last match and the next store; 0 disables the timeout.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-low reset.
- memwrite  in  2: store size of current cycle. 00 none, 01 word (sw), 10 halfword (sh), 11 byte (sb).
- dataadr  in  ADDR_W: store address.
- writedata  in  DATA_W: store data, right-aligned.
- exp_we  in  1: write one expected-table entry.
- exp_idx  in  $clog2(N_EXP): entry index to write.
- exp_addr  in  ADDR_W: expected address.
- exp_data  in  DATA_W: expected data.
- exp_size  in  2: expected size, same encoding as memwrite.
- start  in  1: begin checking at entry 0.
- busy  out  1: high in RUN.
- done  out  1: high in PASS or FAIL.
- pass  out  1: high in PASS.
- fail_code  out  2: 00 none, 01 address/size mismatch, 10 data mismatch, 11 timeout.
- fail_idx  out  $clog2(N_EXP): table index current when FAIL was entered.
- match_cnt  out  $clog2(N_EXP+1): stores matched so far.

Behaviour:
- FSM states: IDLE, RUN, PASS, FAIL.
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs 0; ptr=0; timeout counter=0.
  - Expected table is NOT cleared.
  - Reset mid-RUN aborts with no verdict.
- IDLE:
  - exp_we writes table[exp_idx] at posedge.
  - start moves to RUN next cycle; ptr, match_cnt and counter are cleared.
  - Stores are ignored.
- RUN:
  - exp_we is ignored.
  - A store is any cycle with memwrite!=00. It is compared combinationally against table[ptr]; the verdict is registered at that posedge.
  - Compare rule:
    - Address and size must both be equal, else FAIL code 01.
    - Data is compared on low 32/16/8 bits for word/half/byte. Upper writedata bits are ignored for sh/sb. Mismatch gives FAIL code 10.
    - If address/size mismatch and data mismatch occur together, report 01.
  - On match: ptr++, match_cnt++, counter cleared.
  - When match_cnt reaches N_EXP: PASS on that same posedge, so done and pass are visible the next cycle.
  - Timeout: counter increments each RUN cycle without a store. Reaching TIMEOUT gives FAIL code 11.
  - A store in the expiry cycle takes priority over the timeout.
- PASS/FAIL:
  - Sticky. Further stores are ignored.
  - start re-enters RUN with ptr, match_cnt, counter, fail_code and fail_idx cleared.
- start while in RUN is ignored.
- Counter width is $clog2(TIMEOUT+1) and it saturates.
- ptr never wraps, because PASS is entered first.

Optional Feature:
- Macro STORE_SEQ_CHECKER_LOG_EN.
  - Defined: on entry to PASS, $display "Simulation succeeded". On entry to FAIL, $display "Simulation failed" with the cause, idx, dataadr and writedata.
  - Undefined: no simulation output; RTL behaviour is identical.

Decomposition:
- Package store_chk_pkg holds:
  - typedef enum logic [1:0] st_size_e {ST_NONE, ST_WORD, ST_HALF, ST_BYTE};
  - typedef enum logic [1:0] fail_e {F_NONE, F_ADDR, F_DATA, F_TIMEOUT};
  - typedef enum state_e for the FSM states.
- Sub-module store_lane_cmp: combinational size-masked address/size/data compare, returning addr_ok and data_ok.

Test Plan:
- Single byte store passes:
  - Load N_EXP=1 entry {80, 0x000000FF, byte}; start.
  - Drive sb with dataadr=80, writedata=0x0000AAFF.
  - Required: pass=1, done=1 on the next cycle.
- Full sequence passes:
  - Load 4 entries {84 word 0x12345678; 86 half 0xBEEF; 80 byte 0x7F; 88 word 0}.
  - Drive them in order with idle gaps of 3 cycles.
  - Required: match_cnt goes 1..4, then pass=1.
- Address/size mismatch:
  - Entry 1 expects 86 half; drive 86 byte.
  - Required: fail_code=01, fail_idx=1, match_cnt=1; later stores are ignored.
- Data mismatch:
  - Byte entry expects 0x7F; drive writedata 0xFFFFFF7E.
  - Required: fail_code=10.
  - Also drive writedata 0xFFFFFF7F against the same entry; required: match.
- Timeout:
  - TIMEOUT=16; start with no stores.
  - Required: fail_code=11 asserted exactly 16 cycles after RUN entry.
  - A store on cycle 16 instead: required match with no timeout.
- Reset mid-run:
  - Pull reset low after 2 matches.
  - Required: all outputs 0 and state IDLE.
  - Restart without reloading the table; required: the full sequence passes using the retained table.
